// File: rtl/udp_frame_arbiter.sv
// ---------------------------------------------------------------------------
// UdpFrameArbiter : udp_frame_arbiter
//
// Round-robin, frame-granular arbiter that shares the single byte-stream
// input of the UDP parser between NUM_SRC upstream frame sources. One source
// is granted per frame and keeps the grant until its eof. A stalled source
// is cut off after TIMEOUT_CYCLES cycles without an accepted byte, and a
// runaway source is truncated after MAX_FRAME_LEN bytes. Every aborted frame
// is closed towards the parser with eof+err, and the remainder of the
// source's frame is drained silently so the source never hangs.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   src_data       in   per-source byte, source i on bits [8i+7:8i]
//   src_valid      in   per-source byte valid / request
//   src_eof        in   per-source last byte of frame (with src_valid)
//   src_err        in   per-source frame error (with src_eof)
//   src_ready      out  per-source accept, at most one bit set
//   out_data       out  byte to parser (holds its last value)
//   out_byte_valid out  out_data valid
//   out_eof        out  last byte of frame (with out_byte_valid)
//   out_err        out  frame error (with out_eof)
//   grant_id       out  currently / last granted source
//   busy           out  high while forwarding or flushing a frame
//   abort_cnt      out  saturating count of truncated + timed-out frames
// ---------------------------------------------------------------------------
module udp_frame_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int MAX_FRAME_LEN  = 1518,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [8*NUM_SRC-1:0]         src_data,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC-1:0]           src_eof,
    input  logic [NUM_SRC-1:0]           src_err,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic [7:0]                   out_data,
    output logic                         out_byte_valid,
    output logic                         out_eof,
    output logic                         out_err,
    output logic [$clog2(NUM_SRC)-1:0]   grant_id,
    output logic                         busy,
    output logic [15:0]                  abort_cnt
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_nxt;

    logic [GW-1:0]   last_grant_q;
    logic [GW-1:0]   last_grant_nxt;
    logic [GW-1:0]   grant_nxt;
    logic [15:0]     byte_cnt_q;
    logic [15:0]     byte_cnt_nxt;
    logic [IW-1:0]   idle_cnt_q;
    logic [IW-1:0]   idle_cnt_nxt;

    logic            emit_valid;
    logic            emit_eof;
    logic            emit_err;
    logic [7:0]      emit_data;
    logic            abort_inc;

    logic            sel_valid;
    logic            sel_eof;
    logic            sel_err;
    logic [7:0]      sel_data;
    logic            timeout_hit;
    logic            len_hit;

    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW:0]     rr_sum;
    logic [GW-1:0]   rr_cand;

    // The granted source's lane, selected once so the FSM reads only
    // scalar signals. grant_id is the register holding the current grant.
    assign sel_valid = src_valid[grant_id];
    assign sel_eof   = src_eof[grant_id];
    assign sel_err   = src_err[grant_id];
    assign sel_data  = src_data[{grant_id, 3'b000} +: 8];

    // idle_cnt stops at TIMEOUT_CYCLES-1, so it never wraps; reaching that
    // value and seeing another empty cycle is the timeout event. The length
    // compare is done one bit wider so MAX_FRAME_LEN=65535 cannot alias.
    assign timeout_hit = (idle_cnt_q == IW'(TIMEOUT_CYCLES - 1));
    assign len_hit     = (({1'b0, byte_cnt_q} + 17'd1) == 17'(MAX_FRAME_LEN));

    assign busy = (state_q != ST_IDLE);

    // Round-robin search: walk last_grant+1, last_grant+2, ... modulo
    // NUM_SRC and take the first requesting source. The sum is kept one bit
    // wider than the index so the single conditional subtract is a correct
    // modulo for any NUM_SRC, not only powers of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        rr_cand    = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            rr_sum = {1'b0, last_grant_q} + (GW + 1)'(i);
            if (rr_sum >= (GW + 1)'(NUM_SRC)) begin
                rr_sum = rr_sum - (GW + 1)'(NUM_SRC);
            end
            rr_cand = rr_sum[GW-1:0];
            if (!pick_found && src_valid[rr_cand]) begin
                pick_found = 1'b1;
                pick_idx   = rr_cand;
            end
        end
    end

    // Next-state and datapath decisions. Output strobes default to idle and
    // out_data to its current value, so only the forwarding and filler paths
    // change what the parser sees. In FLUSH the source is still drained
    // (ready held high) but nothing is emitted; eof or a second timeout
    // releases the grant.
    always_comb begin
        state_nxt      = state_q;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant_q;
        byte_cnt_nxt   = byte_cnt_q;
        idle_cnt_nxt   = idle_cnt_q;
        emit_valid     = 1'b0;
        emit_eof       = 1'b0;
        emit_err       = 1'b0;
        emit_data      = out_data;
        abort_inc      = 1'b0;
        src_ready      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_nxt    = pick_idx;
                    state_nxt    = ST_FORWARD;
                    byte_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                end
            end

            ST_FORWARD: begin
                src_ready[grant_id] = 1'b1;
                if (sel_valid) begin
                    emit_valid   = 1'b1;
                    emit_data    = sel_data;
                    byte_cnt_nxt = byte_cnt_q + 16'd1;
                    idle_cnt_nxt = '0;
                    if (sel_eof) begin
                        emit_eof       = 1'b1;
                        emit_err       = sel_err;
                        last_grant_nxt = grant_id;
                        state_nxt      = ST_IDLE;
                    end else if (len_hit) begin
                        emit_eof  = 1'b1;
                        emit_err  = 1'b1;
                        abort_inc = 1'b1;
                        state_nxt = ST_FLUSH;
                    end
                end else if (timeout_hit) begin
                    emit_valid   = 1'b1;
                    emit_data    = 8'h00;
                    emit_eof     = 1'b1;
                    emit_err     = 1'b1;
                    abort_inc    = 1'b1;
                    idle_cnt_nxt = '0;
                    state_nxt    = ST_FLUSH;
                end else begin
                    idle_cnt_nxt = idle_cnt_q + 1'b1;
                end
            end

            ST_FLUSH: begin
                src_ready[grant_id] = 1'b1;
                if (sel_valid) begin
                    idle_cnt_nxt = '0;
                    if (sel_eof) begin
                        last_grant_nxt = grant_id;
                        state_nxt      = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    last_grant_nxt = grant_id;
                    state_nxt      = ST_IDLE;
                end else begin
                    idle_cnt_nxt = idle_cnt_q + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register. Reset drops any frame in flight without emitting an
    // eof for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Grant bookkeeping, counters and the registered parser-side outputs.
    // last_grant resets to the highest index so source 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id       <= '0;
            last_grant_q   <= GW'(NUM_SRC - 1);
            byte_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            out_data       <= 8'h00;
            out_byte_valid <= 1'b0;
            out_eof        <= 1'b0;
            out_err        <= 1'b0;
            abort_cnt      <= 16'h0000;
        end else begin
            grant_id       <= grant_nxt;
            last_grant_q   <= last_grant_nxt;
            byte_cnt_q     <= byte_cnt_nxt;
            idle_cnt_q     <= idle_cnt_nxt;
            out_data       <= emit_data;
            out_byte_valid <= emit_valid;
            out_eof        <= emit_eof;
            out_err        <= emit_err;
            if (abort_inc && (abort_cnt != 16'hFFFF)) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udp_frame_arbiter
//
// Two arbiters share one set of source inputs: dut_a has a large frame
// limit (normal forwarding, round robin, timeout, reset) and dut_b has
// MAX_FRAME_LEN=8 (truncation and the eof-vs-limit tie). Both use
// TIMEOUT_CYCLES=16. Inputs are driven at the falling edge; outputs are
// sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_udp_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src_data = '0;
    logic [3:0]  src_valid = '0;
    logic [3:0]  src_eof = '0;
    logic [3:0]  src_err = '0;

    logic [3:0]  a_src_ready, b_src_ready;
    logic [7:0]  a_out_data, b_out_data;
    logic        a_out_byte_valid, b_out_byte_valid;
    logic        a_out_eof, b_out_eof;
    logic        a_out_err, b_out_err;
    logic [1:0]  a_grant_id, b_grant_id;
    logic        a_busy, b_busy;
    logic [15:0] a_abort_cnt, b_abort_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       eof;
        logic       err;
    } cap_t;

    cap_t qa[$];
    cap_t qb[$];
    int   cyc_cnt = 0;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] data;
        logic       eof;
        logic       err;
        logic       ex_ov;
        logic [7:0] ex_od;
        logic       ex_oe;
        logic       ex_oerr;
        logic [3:0] ex_rdy;
        logic       ex_busy;
        logic [1:0] ex_gid;
    } vec_t;

    vec_t vecs[12];

    udp_frame_arbiter #(
        .NUM_SRC(4), .MAX_FRAME_LEN(1518), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .src_data(src_data), .src_valid(src_valid),
        .src_eof(src_eof), .src_err(src_err),
        .src_ready(a_src_ready), .out_data(a_out_data),
        .out_byte_valid(a_out_byte_valid), .out_eof(a_out_eof),
        .out_err(a_out_err), .grant_id(a_grant_id),
        .busy(a_busy), .abort_cnt(a_abort_cnt)
    );

    udp_frame_arbiter #(
        .NUM_SRC(4), .MAX_FRAME_LEN(8), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .src_data(src_data), .src_valid(src_valid),
        .src_eof(src_eof), .src_err(src_err),
        .src_ready(b_src_ready), .out_data(b_out_data),
        .out_byte_valid(b_out_byte_valid), .out_eof(b_out_eof),
        .out_err(b_out_err), .grant_id(b_grant_id),
        .busy(b_busy), .abort_cnt(b_abort_cnt)
    );

    always #5 clk = ~clk;

    // Record every byte each DUT hands to the parser, with its cycle index,
    // so frame contents and gaps can be checked after a sequence.
    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        if (a_out_byte_valid) qa.push_back('{cyc_cnt, a_out_data, a_out_eof, a_out_err});
        if (b_out_byte_valid) qb.push_back('{cyc_cnt, b_out_data, b_out_eof, b_out_err});
    end

    // Hard stop in case a sequence never terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        src_valid = v.valid;
        src_data  = {4{v.data}};
        src_eof   = v.eof ? v.valid : 4'b0000;
        src_err   = v.err ? v.valid : 4'b0000;
    endtask

    task automatic check_q_entry(input string name, input logic use_b, input int idx,
                                 input logic [7:0] d, input logic e, input logic r);
        cap_t c;
        int   sz;
        sz = use_b ? qb.size() : qa.size();
        if (idx >= sz) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: byte %0d missing, got %0d bytes expected more", name, idx, sz);
        end else begin
            c = use_b ? qb[idx] : qa[idx];
            checkOutput($sformatf("%s[%0d] data", name, idx), 32'(c.data), 32'(d));
            checkOutput($sformatf("%s[%0d] eof", name, idx), 32'(c.eof), 32'(e));
            checkOutput($sformatf("%s[%0d] err", name, idx), 32'(c.err), 32'(r));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        src_valid = '0;
        src_eof   = '0;
        src_err   = '0;
        src_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
    endtask

    task automatic idle_cycles(input int n);
        src_valid = '0;
        src_eof   = '0;
        src_err   = '0;
        repeat (n) @(negedge clk);
    endtask

    // Present one byte on a source and hold it until the selected DUT
    // accepts it. Called and returns at a falling edge.
    task automatic drive_byte(input int src, input logic [7:0] d, input logic eof,
                              input logic err, input logic use_b);
        logic acc;
        int   n;
        src_valid           = '0;
        src_valid[src]      = 1'b1;
        src_data            = '0;
        src_data[src*8 +: 8] = d;
        src_eof             = '0;
        src_eof[src]        = eof;
        src_err             = '0;
        src_err[src]        = err;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = use_b ? b_src_ready[src] : a_src_ready[src];
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept src%0d byte 0x%0h: never accepted, expected accept within 50 cycles", src, d);
        end
    endtask

    initial begin
        int          pos[4];
        logic [3:0]  acc;
        int          order[4];
        int          n;
        logic        found;

        // ---------------- Reset state ----------------
        #12;
        checkOutput("reset a_src_ready", 32'(a_src_ready), 32'h0);
        checkOutput("reset a_out_byte_valid", 32'(a_out_byte_valid), 32'h0);
        checkOutput("reset a_out_data", 32'(a_out_data), 32'h0);
        checkOutput("reset a_out_eof", 32'(a_out_eof), 32'h0);
        checkOutput("reset a_out_err", 32'(a_out_err), 32'h0);
        checkOutput("reset a_grant_id", 32'(a_grant_id), 32'h0);
        checkOutput("reset a_busy", 32'(a_busy), 32'h0);
        checkOutput("reset a_abort_cnt", 32'(a_abort_cnt), 32'h0);
        checkOutput("reset b_busy", 32'(b_busy), 32'h0);

        // ---------------- Test 1: single 10-byte frame on source 1 -------
        $display("[TB] test 1: single frame on source 1");
        vecs[0] = '{4'b0010, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1};
        for (int k = 1; k <= 10; k++) begin
            vecs[k] = '{4'b0010, 8'(k), (k == 10), 1'b0,
                        1'b1, 8'(k), (k == 10), 1'b0,
                        (k == 10) ? 4'b0000 : 4'b0010, (k != 10), 2'd1};
        end
        vecs[11] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("t1[%0d] out_byte_valid", i), 32'(a_out_byte_valid), 32'(vecs[i].ex_ov));
            checkOutput($sformatf("t1[%0d] out_data", i), 32'(a_out_data), 32'(vecs[i].ex_od));
            checkOutput($sformatf("t1[%0d] out_eof", i), 32'(a_out_eof), 32'(vecs[i].ex_oe));
            checkOutput($sformatf("t1[%0d] out_err", i), 32'(a_out_err), 32'(vecs[i].ex_oerr));
            checkOutput($sformatf("t1[%0d] src_ready", i), 32'(a_src_ready), 32'(vecs[i].ex_rdy));
            checkOutput($sformatf("t1[%0d] busy", i), 32'(a_busy), 32'(vecs[i].ex_busy));
            checkOutput($sformatf("t1[%0d] grant_id", i), 32'(a_grant_id), 32'(vecs[i].ex_gid));
            @(negedge clk);
        end

        // ---------------- Test 2: round robin among 0, 2, 3 -------------
        $display("[TB] test 2: round robin with continuous requests");
        do_reset();
        for (int s = 0; s < 4; s++) pos[s] = 0;
        for (int c = 0; c < 24; c++) begin
            src_valid = 4'b1101;
            src_data  = '0;
            src_eof   = '0;
            src_err   = '0;
            for (int s = 0; s < 4; s++) begin
                if (src_valid[s]) begin
                    src_data[s*8 +: 8] = 8'(s * 16 + pos[s]);
                    src_eof[s]         = (pos[s] == 3);
                end
            end
            acc = a_src_ready & src_valid;
            @(posedge clk);
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                if (acc[s]) pos[s] = (pos[s] + 1) % 4;
            end
        end
        idle_cycles(1);
        order = '{0, 2, 3, 0};
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 4; j++) begin
                n = f * 4 + j;
                check_q_entry("t2 stream", 1'b0, n, 8'(order[f] * 16 + j), (j == 3), 1'b0);
                if (n > 0 && n < qa.size()) begin
                    checkOutput($sformatf("t2 gap[%0d]", n), 32'(qa[n].cyc - qa[n-1].cyc),
                                (j == 0) ? 32'd2 : 32'd1);
                end
            end
        end

        // ---------------- Test 3: inactivity timeout on source 0 ---------
        $display("[TB] test 3: stalled source timeout");
        do_reset();
        drive_byte(0, 8'h55, 1'b0, 1'b0, 1'b0);
        idle_cycles(0);
        n     = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (a_out_byte_valid) found = 1'b1;
        end
        checkOutput("t3 timeout cycles", 32'(n), 32'd16);
        checkOutput("t3 filler data", 32'(a_out_data), 32'h00);
        checkOutput("t3 filler eof", 32'(a_out_eof), 32'h1);
        checkOutput("t3 filler err", 32'(a_out_err), 32'h1);
        checkOutput("t3 abort_cnt", 32'(a_abort_cnt), 32'd1);
        checkOutput("t3 flush ready", 32'(a_src_ready), 32'b0001);
        checkOutput("t3 flush busy", 32'(a_busy), 32'h1);
        @(negedge clk);
        check_q_entry("t3 first byte", 1'b0, 0, 8'h55, 1'b0, 1'b0);
        qa.delete();
        drive_byte(0, 8'hA1, 1'b0, 1'b0, 1'b0);
        drive_byte(0, 8'hA2, 1'b0, 1'b0, 1'b0);
        drive_byte(0, 8'hA3, 1'b1, 1'b0, 1'b0);
        idle_cycles(0);
        checkOutput("t3 flushed bytes forwarded", 32'(qa.size()), 32'd0);
        checkOutput("t3 busy after eof", 32'(a_busy), 32'h0);
        checkOutput("t3 abort_cnt after flush", 32'(a_abort_cnt), 32'd1);

        // ---------------- Test 4: truncation at MAX_FRAME_LEN=8 ----------
        $display("[TB] test 4: truncation of a 12-byte frame");
        do_reset();
        for (int i = 0; i < 12; i++) drive_byte(1, 8'(8'h10 + i), (i == 11), 1'b0, 1'b1);
        idle_cycles(2);
        checkOutput("t4 bytes out", 32'(qb.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_q_entry("t4 trunc", 1'b1, i, 8'(8'h10 + i), (i == 7), (i == 7));
        checkOutput("t4 abort_cnt", 32'(b_abort_cnt), 32'd1);
        checkOutput("t4 busy", 32'(b_busy), 32'h0);
        qb.delete();
        for (int i = 0; i < 3; i++) drive_byte(1, 8'(8'h20 + i), (i == 2), 1'b0, 1'b1);
        idle_cycles(2);
        checkOutput("t4 next frame bytes", 32'(qb.size()), 32'd3);
        for (int i = 0; i < 3; i++) check_q_entry("t4 clean", 1'b1, i, 8'(8'h20 + i), (i == 2), 1'b0);
        checkOutput("t4 abort_cnt after clean", 32'(b_abort_cnt), 32'd1);

        // ---------------- Test 5: eof exactly at the length limit -------
        $display("[TB] test 5: eof coincides with length limit");
        do_reset();
        for (int i = 0; i < 8; i++) drive_byte(0, 8'(8'h30 + i), (i == 7), 1'b1, 1'b1);
        idle_cycles(2);
        checkOutput("t5 bytes out err1", 32'(qb.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_q_entry("t5 err1", 1'b1, i, 8'(8'h30 + i), (i == 7), (i == 7));
        checkOutput("t5 abort_cnt err1", 32'(b_abort_cnt), 32'd0);
        qb.delete();
        for (int i = 0; i < 8; i++) drive_byte(0, 8'(8'h40 + i), (i == 7), 1'b0, 1'b1);
        idle_cycles(2);
        checkOutput("t5 bytes out err0", 32'(qb.size()), 32'd8);
        check_q_entry("t5 err0", 1'b1, 7, 8'h47, 1'b1, 1'b0);
        checkOutput("t5 abort_cnt err0", 32'(b_abort_cnt), 32'd0);

        // ---------------- Test 6: asynchronous reset mid-frame ----------
        $display("[TB] test 6: reset in the middle of a frame");
        do_reset();
        drive_byte(2, 8'h40, 1'b0, 1'b0, 1'b0);
        drive_byte(2, 8'h41, 1'b0, 1'b0, 1'b0);
        drive_byte(2, 8'h42, 1'b0, 1'b0, 1'b0);
        src_data[23:16] = 8'h43;
        checkOutput("t6 pre out_byte_valid", 32'(a_out_byte_valid), 32'h1);
        checkOutput("t6 pre grant_id", 32'(a_grant_id), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst src_ready", 32'(a_src_ready), 32'h0);
        checkOutput("t6 rst out_byte_valid", 32'(a_out_byte_valid), 32'h0);
        checkOutput("t6 rst out_data", 32'(a_out_data), 32'h0);
        checkOutput("t6 rst out_eof", 32'(a_out_eof), 32'h0);
        checkOutput("t6 rst grant_id", 32'(a_grant_id), 32'h0);
        checkOutput("t6 rst busy", 32'(a_busy), 32'h0);
        checkOutput("t6 rst b src_ready", 32'(b_src_ready), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        src_valid = 4'b0101;
        src_data  = {8'h00, 8'h43, 8'h00, 8'h60};
        src_eof   = '0;
        src_err   = '0;
        @(posedge clk);
        #1;
        checkOutput("t6 priority grant_id", 32'(a_grant_id), 32'd0);
        checkOutput("t6 priority src_ready", 32'(a_src_ready), 32'b0001);
        checkOutput("t6 priority busy", 32'(a_busy), 32'h1);
        @(negedge clk);
        idle_cycles(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_frame_arbiter.md
Name: udp_frame_arbiter

Overview:
- Round-robin, frame-granular arbiter that shares one byte-stream parser input (ip_data_in / ip_byte_valid / ip_eof / ip_err of the UDP parser) between NUM_SRC upstream frame sources.
- Grants one source per frame and holds the grant until that source's eof.
- Protects the shared parser from stalled or runaway sources with an inactivity timeout and a max-length truncation; every aborted frame is terminated towards the parser with an error.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
MAX_FRAME_LEN, 1518, max bytes forwarded per frame (1..65535)
TIMEOUT_CYCLES, 1024, max consecutive cycles without an accepted byte while granted (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
src_data  in  8*NUM_SRC  per-source byte, source i on bits [8i+7:8i]
src_valid  in  NUM_SRC  per-source byte valid / request
src_eof  in  NUM_SRC  per-source last byte of frame, qualified by src_valid
src_err  in  NUM_SRC  per-source frame error, qualified by src_eof
src_ready  out  NUM_SRC  per-source accept; at most one bit set
out_data  out  8  byte to parser
out_byte_valid  out  1  out_data valid
out_eof  out  1  last byte of frame, only with out_byte_valid
out_err  out  1  frame error, only with out_eof
grant_id  out  $clog2(NUM_SRC)  currently/last granted source
busy  out  1  high in FORWARD or FLUSH
abort_cnt  out  16  saturating count of truncated + timed-out frames

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; out_data 0; grant_id 0
  - last_grant = NUM_SRC-1, so source 0 has first priority
- Accept rule: a byte is accepted when src_valid[g] & src_ready[g].
  - Outputs are registered; an accepted byte appears on out_* exactly 1 cycle later.
- out_byte_valid/out_eof/out_err default to 0 every cycle; out_data holds its last value.
- IDLE:
  - src_ready = 0
  - If any src_valid is set, pick the first set bit searching last_grant+1, last_grant+2, ... (mod NUM_SRC).
  - Register the pick into grant_id; next state FORWARD; clear byte_cnt and idle_cnt.
  - Arbitration costs 1 cycle; no byte is accepted in the IDLE cycle.
- FORWARD:
  - src_ready[grant_id] = 1.
  - On each accepted byte: forward it with out_byte_valid=1; byte_cnt++; idle_cnt=0.
  - Accepted byte with src_eof: out_eof=1, out_err=src_err[g]; last_grant=g; next state IDLE.
  - Accepted byte without eof where byte_cnt+1 == MAX_FRAME_LEN: forward with out_eof=1, out_err=1; abort_cnt++; next state FLUSH.
  - If eof and the length limit coincide, eof wins: normal termination, out_err = src_err only.
  - Cycle with no accepted byte: idle_cnt++. When idle_cnt reaches TIMEOUT_CYCLES-1, the next cycle emits a filler byte (out_data=0x00, out_byte_valid=1, out_eof=1, out_err=1); abort_cnt++; next state FLUSH.
- FLUSH:
  - src_ready[grant_id] = 1; accepted bytes are discarded, nothing is output.
  - Accepted byte with src_eof: last_grant=g; next state IDLE.
  - idle_cnt also runs here; on timeout, silently return to IDLE (no output, no abort_cnt increment); last_grant=g.
- Requests from non-granted sources never get ready and are never dropped; they wait for a later arbitration.
- abort_cnt saturates at 0xFFFF.
- busy = (state != IDLE).
- Widths:
  - byte_cnt is 16 bits.
  - idle_cnt is $clog2(TIMEOUT_CYCLES) bits and must not wrap before the compare.
- Asynchronous reset mid-frame clears all state immediately; no eof is emitted for the interrupted frame.
- Default/illegal state recovers to IDLE.

Test Plan:
- Single source 1 sends a 10-byte frame 0x01..0x0A, eof on the last byte, err=0 → out shows the 10 bytes in order, 1 cycle after acceptance; out_eof with 0x0A; out_err=0; grant_id=1; busy falls after eof.
- Sources 0, 2 and 3 all request continuously with 4-byte frames → grant order 0, 2, 3, 0; 1 idle arbitration cycle between frames; no interleaved bytes.
- Source 0 sends byte 0x55 then stalls with TIMEOUT_CYCLES=16 → after 16 idle cycles, out emits 0x00 with eof=1, err=1; abort_cnt=1; src 0 stays ready until its eof, and those bytes are not forwarded.
- MAX_FRAME_LEN=8, source 1 sends 12 bytes → 8 bytes out, the 8th carrying eof=1, err=1; the remaining 4 are dropped; abort_cnt increments; the next frame is forwarded cleanly.
- MAX_FRAME_LEN=8, 8-byte frame with eof on byte 8 and src_err=1 → out_eof=1, out_err=1, abort_cnt unchanged; same frame with src_err=0 → out_err=0.
- Assert rst_n low mid-frame on source 2 → all outputs 0 and src_ready=0 immediately; after release, source 0 has priority over source 2 when both request.
